sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, successor to the fixed 16x8 sync FIFO; generalised in data width and depth (any DEPTH >= 2, not only powers of two).
Adds an occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses, and same-cycle read/write at the full boundary.
Sits between producer and consumer blocks sharing one clock; flags are registered and exact in the cycle after any accepted access.

---
 rtl/sync_fifo_pkg.sv | 37 +++
 rtl/sync_fifo_param_if.sv | 36 +++
 rtl/sync_fifo_ctrl.sv | 101 ++++++++++
 rtl/sync_fifo_param.sv | 76 +++++++
 tb/tb_sync_fifo_param.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: default sizing,
// width derivation helpers, the wrap-around pointer increment, and the
// encoding of the per-cycle accepted access.
package sync_fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 16;
  // almost_full defaults to DEPTH minus this margin
  localparam int DEF_AF_MARGIN = 2;
  localparam int DEF_AE_THRESH = 2;

  // What the FIFO actually did this cycle, built as {write, read} accepted
  typedef enum logic [1:0] {
    ACC_IDLE = 2'b00,
    ACC_POP  = 2'b01,
    ACC_PUSH = 2'b10,
    ACC_BOTH = 2'b11
  } acc_e;

  // Pointer width: enough bits to address DEPTH entries
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width: must represent 0..DEPTH inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer increment with an explicit wrap at DEPTH-1, so depths that are
  // not powers of two never step into unused addresses
  function automatic logic [31:0] ptr_wrap_inc(input logic [31:0] ptr,
                                               input int depth);
    return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer side of the parametrised FIFO. The master modport is the
// client (issues wr/rd and data_in); the slave modport is the FIFO itself.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic             wr;
  logic [WIDTH-1:0] data_in;
  logic             rd;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr, data_in, rd,
    input  data_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, data_in, rd,
    output data_out, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ctrl.sv
// Control path of the parametrised FIFO: accept logic, read/write pointers,
// occupancy count, registered status flags and overflow/underflow pulses.
// All flags are registered from the next-state count, so they are exact in
// the cycle right after any accepted access.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int AF_THRESH = DEPTH - DEF_AF_MARGIN,
  parameter  int AE_THRESH = DEF_AE_THRESH,
  localparam int ADDR_W    = addr_w(DEPTH),
  localparam int CNT_W     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  output logic              wr_acc,
  output logic              rd_acc,
  output logic [ADDR_W-1:0] wptr,
  output logic [ADDR_W-1:0] rptr,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  acc_e              acc;
  logic [CNT_W-1:0]  count_next;
  logic [ADDR_W-1:0] wptr_inc;
  logic [ADDR_W-1:0] rptr_inc;

  // A read needs data; a write needs room, or a slot freed by a same-cycle read
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);
  assign acc    = acc_e'({wr_acc, rd_acc});

  assign wptr_inc = ADDR_W'(ptr_wrap_inc(32'(wptr), DEPTH));
  assign rptr_inc = ADDR_W'(ptr_wrap_inc(32'(rptr), DEPTH));

  // Occupancy after this cycle's accepted accesses
  always_comb begin
    // NOTE: assign a default before the case so every path drives count_next
    // and no latch is inferred.
    count_next = count;
    case (acc)
      ACC_PUSH: count_next = count + CNT_W'(1);
      ACC_POP:  count_next = count - CNT_W'(1);
      default:  count_next = count;  // idle, or push+pop cancel out
    endcase
  end

  // Read/write pointers, each advancing only on its own accepted access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr_inc;
      if (rd_acc) rptr <= rptr_inc;
    end
  end

  // Occupancy count and status flags, all derived from the next count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (AF_C == '0);
      almost_empty <= 1'b1;
    end else begin
      count        <= count_next;
      full         <= (count_next == DEPTH_C);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
    end
  end

  // One-cycle error pulses for each rejected request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr & ~wr_acc;
      underflow <= rd & ~rd_acc;
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO (any WIDTH >= 1, any DEPTH >= 2) with
// occupancy count, programmable almost-full/almost-empty flags and
// overflow/underflow pulses. A write to a full FIFO is accepted when a read
// is accepted in the same cycle.
//
// Build option SYNC_FIFO_FWFT_EN: first-word-fall-through. When defined,
// data_out shows the head entry combinationally whenever the FIFO is not
// empty and rd pops it. When undefined, data_out is a register loaded one
// cycle after an accepted read and held otherwise.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input logic               clk,
  input logic               rst_n,
  sync_fifo_param_if.slave  bus
);

  localparam int ADDR_W = addr_w(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;

  sync_fifo_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (bus.wr),
    .rd           (bus.rd),
    .wr_acc       (wr_acc),
    .rd_acc       (rd_acc),
    .wptr         (wptr),
    .rptr         (rptr),
    .count        (bus.count),
    .full         (bus.full),
    .empty        (bus.empty),
    .almost_full  (bus.almost_full),
    .almost_empty (bus.almost_empty),
    .overflow     (bus.overflow),
    .underflow    (bus.underflow)
  );

  // Storage write; independent of the read so both can happen in one cycle.
  // When full, wptr == rptr: the read below still sees the old word because
  // both sides sample pre-edge memory contents.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; pointers and count define which
    // entries are valid, and leaving it unreset lets it map onto RAM.
    if (wr_acc) mem[wptr] <= bus.data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is always visible; meaningful only while not empty
  assign bus.data_out = mem[rptr];
`else
  // Registered read port: loads the head entry on an accepted read, holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out <= '0;
    end else if (rd_acc) begin
      bus.data_out <= mem[rptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a DEPTH=16 and a DEPTH=5 instance, each shadowed
// by a queue model of the FIFO's rules, checked on every falling edge, plus
// directed vectors with hand-computed literal expectations.
module tb_sync_fifo_param;

  localparam int W   = 8;
  localparam int D   = 16;
  localparam int AF  = 14;
  localparam int AE  = 2;
  localparam int D5  = 5;
  localparam int AF5 = 4;
  localparam int AE5 = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   live  = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D))  bus  ();
  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D5)) bus5 ();

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sync_fifo_param #(.WIDTH(W), .DEPTH(D5), .AF_THRESH(AF5), .AE_THRESH(AE5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference models (queue of stored words) ----------------
  logic [W-1:0] q16[$];
  logic [W-1:0] q5[$];
  logic [W-1:0] m_dout16, m_dout5;
  logic         m_ovf16, m_udf16, m_ovf5, m_udf5;

  always @(posedge clk or negedge rst_n) begin
    bit r_ok, w_ok;
    if (!rst_n) begin
      q16.delete(); m_dout16 = '0; m_ovf16 = 1'b0; m_udf16 = 1'b0;
    end else begin
      r_ok = bus.rd && (q16.size() > 0);
      w_ok = bus.wr && ((q16.size() < D) || r_ok);
      m_ovf16 = bus.wr && !w_ok;
      m_udf16 = bus.rd && !r_ok;
      if (r_ok) m_dout16 = q16.pop_front();
      if (w_ok) q16.push_back(bus.data_in);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    bit r_ok, w_ok;
    if (!rst_n) begin
      q5.delete(); m_dout5 = '0; m_ovf5 = 1'b0; m_udf5 = 1'b0;
    end else begin
      r_ok = bus5.rd && (q5.size() > 0);
      w_ok = bus5.wr && ((q5.size() < D5) || r_ok);
      m_ovf5 = bus5.wr && !w_ok;
      m_udf5 = bus5.rd && !r_ok;
      if (r_ok) m_dout5 = q5.pop_front();
      if (w_ok) q5.push_back(bus5.data_in);
    end
  end

  // ---------------- per-cycle compare against the models ----------------
  always @(negedge clk) begin
    if (rst_n && live) begin
      check("m16.count", 32'(bus.count),        32'(q16.size()));
      check("m16.full",  32'(bus.full),         32'(q16.size() == D));
      check("m16.empty", 32'(bus.empty),        32'(q16.size() == 0));
      check("m16.afull", 32'(bus.almost_full),  32'(q16.size() >= AF));
      check("m16.aempt", 32'(bus.almost_empty), 32'(q16.size() <= AE));
      check("m16.ovf",   32'(bus.overflow),     32'(m_ovf16));
      check("m16.udf",   32'(bus.underflow),    32'(m_udf16));
`ifdef SYNC_FIFO_FWFT_EN
      if (q16.size() > 0) check("m16.dout", 32'(bus.data_out), 32'(q16[0]));
`else
      check("m16.dout",  32'(bus.data_out),     32'(m_dout16));
`endif
      check("m5.count",  32'(bus5.count),        32'(q5.size()));
      check("m5.full",   32'(bus5.full),         32'(q5.size() == D5));
      check("m5.empty",  32'(bus5.empty),        32'(q5.size() == 0));
      check("m5.afull",  32'(bus5.almost_full),  32'(q5.size() >= AF5));
      check("m5.aempt",  32'(bus5.almost_empty), 32'(q5.size() <= AE5));
      check("m5.ovf",    32'(bus5.overflow),     32'(m_ovf5));
      check("m5.udf",    32'(bus5.underflow),    32'(m_udf5));
`ifdef SYNC_FIFO_FWFT_EN
      if (q5.size() > 0) check("m5.dout", 32'(bus5.data_out), 32'(q5[0]));
`else
      check("m5.dout",   32'(bus5.data_out),     32'(m_dout5));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drive one access, let one rising edge pass, return 1 time unit after it
  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r);
    bus.wr = w; bus.data_in = d; bus.rd = r;
    @(posedge clk); #1;
    bus.wr = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic cyc5(input logic w, input logic [W-1:0] d, input logic r);
    bus5.wr = w; bus5.data_in = d; bus5.rd = r;
    @(posedge clk); #1;
    bus5.wr = 1'b0; bus5.rd = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed vectors ----------------
  initial begin
    bus.wr  = 1'b0; bus.rd  = 1'b0; bus.data_in  = '0;
    bus5.wr = 1'b0; bus5.rd = 1'b0; bus5.data_in = '0;

    // Reset, then idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    live = 1'b1;
    check("rst.count", 32'(bus.count), 32'd0);
    check("rst.empty", 32'(bus.empty), 32'd1);
    check("rst.aempt", 32'(bus.almost_empty), 32'd1);
    check("rst.full",  32'(bus.full), 32'd0);
    check("rst.afull", 32'(bus.almost_full), 32'd0);
    check("rst.ovf",   32'(bus.overflow), 32'd0);
    check("rst.udf",   32'(bus.underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst.dout",  32'(bus.data_out), 32'd0);
`endif
    idle();

    // Fill with 0x00..0x0F
    for (int i = 0; i < D; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 12) check("fill13.afull", 32'(bus.almost_full), 32'd0);
      if (i == 13) begin
        check("fill14.count", 32'(bus.count), 32'd14);
        check("fill14.afull", 32'(bus.almost_full), 32'd1);
      end
      if (i == 14) check("fill15.full", 32'(bus.full), 32'd0);
      if (i == 15) begin
        check("fill16.full",  32'(bus.full), 32'd1);
        check("fill16.count", 32'(bus.count), 32'd16);
      end
    end

    // 17th write overflows for exactly one cycle
    cyc(1'b1, 8'h55, 1'b0);
    check("ovf.pulse", 32'(bus.overflow), 32'd1);
    check("ovf.count", 32'(bus.count), 32'd16);
    idle();
    check("ovf.clear", 32'(bus.overflow), 32'd0);

    // Drain all 16 in order
    for (int i = 0; i < D; i++) begin
      cyc(1'b0, '0, 1'b1);
      check("drain.count", 32'(bus.count), 32'(15 - i));
`ifdef SYNC_FIFO_FWFT_EN
      if (i < D - 1) check("drain.head", 32'(bus.data_out), 32'(i + 1));
`else
      check("drain.dout", 32'(bus.data_out), 32'(i));
`endif
    end
    check("drain.empty", 32'(bus.empty), 32'd1);

    // Read while empty underflows; registered data_out holds the last word
    cyc(1'b0, '0, 1'b1);
    check("udf.pulse", 32'(bus.underflow), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    check("udf.hold", 32'(bus.data_out), 32'h0F);
`endif
    idle();
    check("udf.clear", 32'(bus.underflow), 32'd0);

    // Empty with wr+rd: write accepted, read rejected
    cyc(1'b1, 8'h77, 1'b1);
    check("ewr.count", 32'(bus.count), 32'd1);
    check("ewr.udf",   32'(bus.underflow), 32'd1);
    check("ewr.empty", 32'(bus.empty), 32'd0);
    cyc(1'b0, '0, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    check("ewr.dout", 32'(bus.data_out), 32'h77);
`endif
    check("ewr.count0", 32'(bus.count), 32'd0);

    // Full boundary: simultaneous rd+wr keeps count at DEPTH
    for (int i = 0; i < D; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    cyc(1'b1, 8'hAA, 1'b1);
    check("fb.full",  32'(bus.full), 32'd1);
    check("fb.count", 32'(bus.count), 32'd16);
    check("fb.ovf",   32'(bus.overflow), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fb.head", 32'(bus.data_out), 32'h11);
`else
    check("fb.dout", 32'(bus.data_out), 32'h10);
`endif
    for (int i = 0; i < D; i++) begin
      cyc(1'b0, '0, 1'b1);
`ifdef SYNC_FIFO_FWFT_EN
      if (i == D - 2) check("fb.lasthead", 32'(bus.data_out), 32'hAA);
`else
      if (i == D - 1) check("fb.last", 32'(bus.data_out), 32'hAA);
`endif
    end

    // DEPTH=5 instance: prime 3, then 12 wr+rd pairs across wrap-around
    cyc5(1'b1, 8'h40, 1'b0);
    cyc5(1'b1, 8'h41, 1'b0);
    cyc5(1'b1, 8'h42, 1'b0);
    check("d5.prime", 32'(bus5.count), 32'd3);
    for (int k = 0; k < 12; k++) begin
      cyc5(1'b1, 8'(8'h43 + k), 1'b1);
      check("d5.pair.count", 32'(bus5.count), 32'd3);
`ifdef SYNC_FIFO_FWFT_EN
      check("d5.pair.head", 32'(bus5.data_out), 32'(8'h41 + k));
`else
      check("d5.pair.dout", 32'(bus5.data_out), 32'(8'h40 + k));
`endif
    end
    cyc5(1'b1, 8'h4F, 1'b0);
    check("d5.af", 32'(bus5.almost_full), 32'd1);
    check("d5.nf", 32'(bus5.full), 32'd0);
    cyc5(1'b1, 8'h50, 1'b0);
    check("d5.full", 32'(bus5.full), 32'd1);
    cyc5(1'b1, 8'h51, 1'b0);
    check("d5.ovf",   32'(bus5.overflow), 32'd1);
    check("d5.count", 32'(bus5.count), 32'd5);
    for (int k = 0; k < D5; k++) begin
      cyc5(1'b0, '0, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
      check("d5.drain", 32'(bus5.data_out), 32'(8'h4C + k));
`endif
      if (k == 2) check("d5.ae2", 32'(bus5.almost_empty), 32'd0);
      if (k == 3) check("d5.ae1", 32'(bus5.almost_empty), 32'd1);
    end
    check("d5.empty", 32'(bus5.empty), 32'd1);

    // Reset in the middle of activity
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    bus.wr = 1'b1; bus.data_in = 8'h99;
    #2 rst_n = 1'b0;
    #1;
    check("mrst.count", 32'(bus.count), 32'd0);
    check("mrst.empty", 32'(bus.empty), 32'd1);
    check("mrst.aempt", 32'(bus.almost_empty), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    check("mrst.dout", 32'(bus.data_out), 32'd0);
`endif
    @(posedge clk); #1;
    check("mrst.discard", 32'(bus.count), 32'd0);
    bus.wr = 1'b0;
    rst_n = 1'b1;
    idle();
    check("mrst.idle", 32'(bus.empty), 32'd1);

    // Single word into an empty FIFO
    cyc(1'b1, 8'h3C, 1'b0);
    check("w3c.empty", 32'(bus.empty), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
    check("w3c.head", 32'(bus.data_out), 32'h3C);
`else
    check("w3c.nolat", 32'(bus.data_out), 32'd0);
`endif
    cyc(1'b0, '0, 1'b1);
    check("w3c.pop", 32'(bus.empty), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    check("w3c.dout", 32'(bus.data_out), 32'h3C);
`endif

    idle();
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
